// File: rtl/maxuhp_pkg.sv
// Shared mode encodings, IEEE-754 single-precision constants and a width helper
// for the multi-channel maxu*x+C datapath.
package maxuhp_pkg;

  typedef enum logic [1:0] {
    MODE_ADD_ONE      = 2'd0,
    MODE_SUB_ONE      = 2'd1,
    MODE_ADD_ZERO     = 2'd2,
    MODE_ADD_ZERO_ALT = 2'd3
  } mode_e;

  localparam logic [31:0] FP_POS_ZERO  = 32'h0000_0000;
  localparam logic [31:0] FP_SIGN_MASK = 32'h8000_0000;
  localparam logic [31:0] FP_POS_ONE   = 32'h3F80_0000;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/maxuhp_tag_fifo.sv
// In-order tag store for outstanding operations: one write pointer and separate
// read pointers for the multiply and add stages, each with its own empty flag.
module maxuhp_tag_fifo
  import maxuhp_pkg::*;
#(
  parameter int C_DEPTH = 16,
  parameter int C_CH_W  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [C_CH_W-1:0] i_pushCh,
  input  logic [1:0]        i_pushMode,
  input  logic              i_multPop,
  input  logic              i_addPop,
  output logic [1:0]        o_multMode,
  output logic [C_CH_W-1:0] o_addCh,
  output logic              o_full,
  output logic              o_multEmpty,
  output logic              o_addEmpty
);

  localparam int PTR_W = clog2(C_DEPTH);

  logic [PTR_W:0]      r_wrPtr;
  logic [PTR_W:0]      r_multPtr;
  logic [PTR_W:0]      r_addPtr;
  logic [C_CH_W-1:0]   r_chMem   [C_DEPTH];
  logic [1:0]          r_modeMem [C_DEPTH];
  logic                w_push;
  logic                w_multPop;
  logic                w_addPop;

  // Extra MSB on each pointer distinguishes full from empty after wrap.
  assign o_full      = (r_wrPtr[PTR_W] != r_addPtr[PTR_W]) &&
                       (r_wrPtr[PTR_W-1:0] == r_addPtr[PTR_W-1:0]);
  assign o_multEmpty = (r_wrPtr == r_multPtr);
  assign o_addEmpty  = (r_multPtr == r_addPtr);

  assign w_push    = i_push && !o_full;
  assign w_multPop = i_multPop && !o_multEmpty;
  assign w_addPop  = i_addPop && !o_addEmpty;

  assign o_multMode = r_modeMem[r_multPtr[PTR_W-1:0]];
  assign o_addCh    = r_chMem[r_addPtr[PTR_W-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wrPtr   <= '0;
      r_multPtr <= '0;
      r_addPtr  <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_multPop) begin
        r_multPtr <= r_multPtr + 1'b1;
      end
      if (w_addPop) begin
        r_addPtr <= r_addPtr + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_chMem[r_wrPtr[PTR_W-1:0]]   <= i_pushCh;
      r_modeMem[r_wrPtr[PTR_W-1:0]] <= i_pushMode;
    end
  end

endmodule

// File: rtl/maxuhp_mc.sv
// Multi-channel front end that computes maxu*x +/- C through an external FP
// multiplier and adder, arbitrating channels round-robin and retiring in order.
module maxuhp_mc
  import maxuhp_pkg::*;
#(
  parameter int                      C_DATA_WIDTH = 32,
  parameter int                      C_CH_NUM     = 4,
  parameter int                      C_TAG_DEPTH  = 16,
  parameter logic [C_DATA_WIDTH-1:0] C_ADD_CONST  = C_DATA_WIDTH'(FP_POS_ONE)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [C_CH_NUM-1:0]              ch_in_valid,
  output logic [C_CH_NUM-1:0]              ch_in_ready,
  input  logic [C_CH_NUM*C_DATA_WIDTH-1:0] ch_in_data,
  input  logic [C_CH_NUM*C_DATA_WIDTH-1:0] ch_maxu_in,
  input  logic [1:0]                       mode,
  output logic [C_DATA_WIDTH-1:0]          mult_a,
  output logic [C_DATA_WIDTH-1:0]          mult_b,
  output logic                             mult_valid,
  input  logic [C_DATA_WIDTH-1:0]          mult_result,
  input  logic                             mult_rdy,
  output logic [C_DATA_WIDTH-1:0]          add_a,
  output logic [C_DATA_WIDTH-1:0]          add_b,
  output logic                             add_valid,
  input  logic [C_DATA_WIDTH-1:0]          add_result,
  input  logic                             add_rdy,
  output logic                             dataf_out_valid,
  output logic [C_DATA_WIDTH-1:0]          dataf_out,
  output logic [clog2(C_CH_NUM)-1:0]       dataf_out_ch,
  output logic                             seq_err
);

  localparam int CH_W  = clog2(C_CH_NUM);
  localparam int CNT_W = clog2(C_TAG_DEPTH) + 1;

  logic [C_CH_NUM-1:0]     r_full;
  logic [C_CH_NUM-1:0]     r_ready;
  logic [C_DATA_WIDTH-1:0] r_x    [C_CH_NUM];
  logic [C_DATA_WIDTH-1:0] r_maxu [C_CH_NUM];
  logic [1:0]              r_mode [C_CH_NUM];
  logic [CH_W-1:0]         r_rrPtr;
  logic [CNT_W-1:0]        r_outstanding;

  logic [C_DATA_WIDTH-1:0] r_multA;
  logic [C_DATA_WIDTH-1:0] r_multB;
  logic                    r_multValid;
  logic [C_DATA_WIDTH-1:0] r_addA;
  logic [C_DATA_WIDTH-1:0] r_addB;
  logic                    r_addValid;
  logic                    r_outValid;
  logic [C_DATA_WIDTH-1:0] r_outData;
  logic [CH_W-1:0]         r_outCh;
  logic                    r_seqErr;

  logic [C_CH_NUM-1:0]     w_fullNxt;
  logic                    w_grantAny;
  logic [CH_W-1:0]         w_grantIdx;
  logic [CH_W:0]           w_sum;
  logic                    w_issue;
  logic                    w_tagFull;
  logic                    w_multEmpty;
  logic                    w_addEmpty;
  logic                    w_multAccept;
  logic                    w_addAccept;
  logic [1:0]              w_multMode;
  logic [CH_W-1:0]         w_addCh;
  logic [C_DATA_WIDTH-1:0] w_addend;

  // Scan downward from the farthest offset so the channel nearest r_rrPtr wins.
  always_comb begin
    w_grantAny = 1'b0;
    w_grantIdx = '0;
    w_sum      = '0;
    for (int i = C_CH_NUM - 1; i >= 0; i--) begin
      w_sum = {1'b0, r_rrPtr} + (CH_W+1)'(i);
      if (w_sum >= (CH_W+1)'(C_CH_NUM)) begin
        w_sum = w_sum - (CH_W+1)'(C_CH_NUM);
      end
      if (r_full[w_sum[CH_W-1:0]]) begin
        w_grantAny = 1'b1;
        w_grantIdx = w_sum[CH_W-1:0];
      end
    end
  end

  assign w_issue      = w_grantAny && !w_tagFull &&
                        (r_outstanding < CNT_W'(C_TAG_DEPTH));
  assign w_multAccept = mult_rdy && !w_multEmpty;
  assign w_addAccept  = add_rdy && !w_addEmpty;

  always_comb begin
    w_fullNxt = r_full;
    for (int k = 0; k < C_CH_NUM; k++) begin
      if (w_issue && (w_grantIdx == CH_W'(k))) begin
        w_fullNxt[k] = 1'b0;
      end else if (ch_in_valid[k] && r_ready[k]) begin
        w_fullNxt[k] = 1'b1;
      end
    end
  end

  always_comb begin
    case (mode_e'(w_multMode))
      MODE_ADD_ONE: w_addend = C_ADD_CONST;
      MODE_SUB_ONE: w_addend = C_ADD_CONST ^ C_DATA_WIDTH'(FP_SIGN_MASK);
      default:      w_addend = C_DATA_WIDTH'(FP_POS_ZERO);
    endcase
  end

  // Ready is a registered copy of the empty state, so a slot freed by issue
  // only reopens to the producer on the following cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full        <= '0;
      r_ready       <= '0;
      r_rrPtr       <= '0;
      r_outstanding <= '0;
      for (int k = 0; k < C_CH_NUM; k++) begin
        r_x[k]    <= '0;
        r_maxu[k] <= '0;
        r_mode[k] <= '0;
      end
    end else begin
      r_full  <= w_fullNxt;
      r_ready <= ~w_fullNxt;
      for (int k = 0; k < C_CH_NUM; k++) begin
        if (ch_in_valid[k] && r_ready[k]) begin
          r_x[k]    <= ch_in_data[k*C_DATA_WIDTH +: C_DATA_WIDTH];
          r_maxu[k] <= ch_maxu_in[k*C_DATA_WIDTH +: C_DATA_WIDTH];
          r_mode[k] <= mode;
        end
      end
      if (w_issue) begin
        r_rrPtr <= (w_grantIdx == CH_W'(C_CH_NUM - 1)) ? '0 : w_grantIdx + 1'b1;
      end
      if (w_issue && !w_addAccept) begin
        r_outstanding <= r_outstanding + 1'b1;
      end else if (!w_issue && w_addAccept) begin
        r_outstanding <= r_outstanding - 1'b1;
      end
    end
  end

  // Every outward-facing signal is registered and cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_multA     <= '0;
      r_multB     <= '0;
      r_multValid <= 1'b0;
      r_addA      <= '0;
      r_addB      <= '0;
      r_addValid  <= 1'b0;
      r_outValid  <= 1'b0;
      r_outData   <= '0;
      r_outCh     <= '0;
      r_seqErr    <= 1'b0;
    end else begin
      r_multValid <= w_issue;
      if (w_issue) begin
        r_multA <= r_maxu[w_grantIdx];
        r_multB <= r_x[w_grantIdx];
      end
      r_addValid <= w_multAccept;
      if (w_multAccept) begin
        r_addA <= mult_result;
        r_addB <= w_addend;
      end
      r_outValid <= w_addAccept;
      if (w_addAccept) begin
        r_outData <= add_result;
        r_outCh   <= w_addCh;
      end
      if ((mult_rdy && w_multEmpty) || (add_rdy && w_addEmpty)) begin
        r_seqErr <= 1'b1;
      end
    end
  end

  maxuhp_tag_fifo #(
    .C_DEPTH (C_TAG_DEPTH),
    .C_CH_W  (CH_W)
  ) u_tagFifo (
    .i_clk       (clk),
    .i_rst_n     (reset),
    .i_push      (w_issue),
    .i_pushCh    (w_grantIdx),
    .i_pushMode  (r_mode[w_grantIdx]),
    .i_multPop   (w_multAccept),
    .i_addPop    (w_addAccept),
    .o_multMode  (w_multMode),
    .o_addCh     (w_addCh),
    .o_full      (w_tagFull),
    .o_multEmpty (w_multEmpty),
    .o_addEmpty  (w_addEmpty)
  );

  assign ch_in_ready     = r_ready;
  assign mult_a          = r_multA;
  assign mult_b          = r_multB;
  assign mult_valid      = r_multValid;
  assign add_a           = r_addA;
  assign add_b           = r_addB;
  assign add_valid       = r_addValid;
  assign dataf_out_valid = r_outValid;
  assign dataf_out       = r_outData;
  assign dataf_out_ch    = r_outCh;
  assign seq_err         = r_seqErr;

endmodule

// File: tb/tb_maxuhp_mc.sv
// Self-checking bench for maxuhp_mc with behavioural models of the external
// FP multiplier and adder, and a scoreboard of expected issue/add/output values.
module tb_maxuhp_mc;

  logic         clk;
  logic         reset;
  logic [3:0]   ch_in_valid;
  logic [3:0]   ch_in_ready;
  logic [127:0] ch_in_data;
  logic [127:0] ch_maxu_in;
  logic [1:0]   mode;
  logic [31:0]  mult_a;
  logic [31:0]  mult_b;
  logic         mult_valid;
  logic [31:0]  mult_result;
  logic         mult_rdy;
  logic [31:0]  add_a;
  logic [31:0]  add_b;
  logic         add_valid;
  logic [31:0]  add_result;
  logic         add_rdy;
  logic         dataf_out_valid;
  logic [31:0]  dataf_out;
  logic [1:0]   dataf_out_ch;
  logic         seq_err;

  maxuhp_mc dut (
    .clk             (clk),
    .reset           (reset),
    .ch_in_valid     (ch_in_valid),
    .ch_in_ready     (ch_in_ready),
    .ch_in_data      (ch_in_data),
    .ch_maxu_in      (ch_maxu_in),
    .mode            (mode),
    .mult_a          (mult_a),
    .mult_b          (mult_b),
    .mult_valid      (mult_valid),
    .mult_result     (mult_result),
    .mult_rdy        (mult_rdy),
    .add_a           (add_a),
    .add_b           (add_b),
    .add_valid       (add_valid),
    .add_result      (add_result),
    .add_rdy         (add_rdy),
    .dataf_out_valid (dataf_out_valid),
    .dataf_out       (dataf_out),
    .dataf_out_ch    (dataf_out_ch),
    .seq_err         (seq_err)
  );

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] data;
  } out_t;

  typedef struct {
    int          ch;
    logic [31:0] x;
    logic [31:0] maxu;
    logic [1:0]  md;
    logic [31:0] addB;
    logic [31:0] out;
  } vec_t;

  int          checks;
  int          failures;
  int          cyc;
  int          issueCount;
  int          addValidCount;
  int          outCount;
  bit          multEn;
  bit          addEn;
  bit          forceMult;
  bit          forceAdd;
  bit          offersDone;
  logic [63:0] issueQ [$];
  logic [31:0] addBQ [$];
  out_t        outQ [$];
  logic [31:0] mulQ [$];
  logic [31:0] addQ [$];
  int          issueCycQ [$];
  vec_t        vecs [8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  function automatic logic [31:0] fakeMul(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40400000 && b == 32'h40000000) return 32'h40C00000;
    return a ^ {b[15:0], b[31:16]};
  endfunction

  function automatic logic [31:0] fakeAdd(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C00000 && b == 32'h3F800000) return 32'h40E00000;
    if (a == 32'h40C00000 && b == 32'hBF800000) return 32'h40A00000;
    if (a == 32'h40C00000 && b == 32'h00000000) return 32'h40C00000;
    return a + b;
  endfunction

  function automatic logic [31:0] expAddB(input logic [1:0] md);
    if (md == 2'd0) return 32'h3F800000;
    if (md == 2'd1) return 32'hBF800000;
    return 32'h00000000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // External unit models and output monitor, all sampling on the falling edge.
  always @(negedge clk) begin
    if (forceMult) begin
      mult_rdy = 1'b1;
      mult_result = 32'hDEADBEEF;
    end else if (multEn && mulQ.size() > 0) begin
      mult_rdy = 1'b1;
      mult_result = mulQ.pop_front();
    end else begin
      mult_rdy = 1'b0;
    end
    if (forceAdd) begin
      add_rdy = 1'b1;
      add_result = 32'hCAFEF00D;
    end else if (addEn && addQ.size() > 0) begin
      add_rdy = 1'b1;
      add_result = addQ.pop_front();
    end else begin
      add_rdy = 1'b0;
    end
    if (mult_valid) begin
      issueCount++;
      issueCycQ.push_back(cyc);
      if (issueQ.size() == 0) begin
        checkOutput("unexpected_issue", 32'(issueQ.size()), 32'd1);
      end else begin
        logic [63:0] e;
        e = issueQ.pop_front();
        checkOutput("mult_a", mult_a, e[63:32]);
        checkOutput("mult_b", mult_b, e[31:0]);
      end
      mulQ.push_back(fakeMul(mult_a, mult_b));
    end
    if (add_valid) begin
      addValidCount++;
      if (addBQ.size() == 0) begin
        checkOutput("unexpected_add", 32'(addBQ.size()), 32'd1);
      end else begin
        checkOutput("add_b", add_b, addBQ.pop_front());
      end
      addQ.push_back(fakeAdd(add_a, add_b));
    end
    if (dataf_out_valid) begin
      outCount++;
      if (outQ.size() == 0) begin
        checkOutput("unexpected_out", 32'(outQ.size()), 32'd1);
      end else begin
        out_t o;
        o = outQ.pop_front();
        checkOutput("out_data", dataf_out, o.data);
        checkOutput("out_ch", 32'(dataf_out_ch), 32'(o.ch));
      end
    end
  end

  task automatic pushExpect(input int ch, input logic [31:0] x, input logic [31:0] maxu,
                            input logic [31:0] addB, input logic [31:0] out);
    out_t o;
    o.ch = 2'(ch);
    o.data = out;
    issueQ.push_back({maxu, x});
    addBQ.push_back(addB);
    outQ.push_back(o);
  endtask

  task automatic applyStimulus(input int ch, input logic [31:0] x, input logic [31:0] maxu,
                               input logic [1:0] md, input logic [31:0] addB,
                               input logic [31:0] out);
    int n;
    pushExpect(ch, x, maxu, addB, out);
    @(posedge clk);
    #1;
    ch_in_valid[ch] = 1'b1;
    ch_in_data[ch*32 +: 32] = x;
    ch_maxu_in[ch*32 +: 32] = maxu;
    mode = md;
    n = 0;
    @(negedge clk);
    while (!ch_in_ready[ch] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!ch_in_ready[ch]) begin
      checkOutput("offer_timeout", 32'(ch_in_ready[ch]), 32'd1);
    end
    @(posedge clk);
    #1;
    ch_in_valid[ch] = 1'b0;
  endtask

  task automatic offerOp(input int ch, input logic [31:0] x, input logic [31:0] maxu,
                         input logic [1:0] md);
    applyStimulus(ch, x, maxu, md, expAddB(md), fakeAdd(fakeMul(maxu, x), expAddB(md)));
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (outQ.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput(name, 32'(outQ.size()), 32'd0);
  endtask

  task automatic doReset(input bit clearModels);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_ready", 32'(ch_in_ready), 32'd0);
    checkOutput("rst_flags", 32'({mult_valid, add_valid, dataf_out_valid, seq_err}), 32'd0);
    checkOutput("rst_data", mult_a | mult_b | add_a | add_b | dataf_out, 32'd0);
    checkOutput("rst_ch", 32'(dataf_out_ch), 32'd0);
    issueQ.delete();
    addBQ.delete();
    outQ.delete();
    if (clearModels) begin
      mulQ.delete();
      addQ.delete();
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("release_ready", 32'(ch_in_ready), 32'hF);
  endtask

  initial begin
    int base;
    int baseOut;
    int n;
    checks = 0;
    failures = 0;
    cyc = 0;
    issueCount = 0;
    addValidCount = 0;
    outCount = 0;
    reset = 1'b0;
    ch_in_valid = '0;
    ch_in_data = '0;
    ch_maxu_in = '0;
    mode = 2'd0;
    mult_rdy = 1'b0;
    mult_result = '0;
    add_rdy = 1'b0;
    add_result = '0;
    multEn = 1'b1;
    addEn = 1'b1;
    forceMult = 1'b0;
    forceAdd = 1'b0;
    offersDone = 1'b0;

    vecs[0] = '{0, 32'h40000000, 32'h40400000, 2'd0, 32'h3F800000, 32'h40E00000};
    vecs[1] = '{0, 32'h40000000, 32'h40400000, 2'd1, 32'hBF800000, 32'h40A00000};
    vecs[2] = '{0, 32'h40000000, 32'h40400000, 2'd2, 32'h00000000, 32'h40C00000};
    vecs[3] = '{1, 32'h40000000, 32'h40400000, 2'd3, 32'h00000000, 32'h40C00000};
    vecs[4] = '{2, 32'h12345678, 32'h0BADF00D, 2'd0, 32'h3F800000,
                fakeAdd(fakeMul(32'h0BADF00D, 32'h12345678), 32'h3F800000)};
    vecs[5] = '{3, 32'hA5A5A5A5, 32'h3C003C00, 2'd1, 32'hBF800000,
                fakeAdd(fakeMul(32'h3C003C00, 32'hA5A5A5A5), 32'hBF800000)};
    vecs[6] = '{1, 32'h00000001, 32'hFFFFFFFF, 2'd2, 32'h00000000,
                fakeAdd(fakeMul(32'hFFFFFFFF, 32'h00000001), 32'h00000000)};
    vecs[7] = '{3, 32'h7F7FFFFF, 32'h40400000, 2'd0, 32'h3F800000,
                fakeAdd(fakeMul(32'h40400000, 32'h7F7FFFFF), 32'h3F800000)};

    doReset(1'b1);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].ch, vecs[i].x, vecs[i].maxu, vecs[i].md, vecs[i].addB, vecs[i].out);
      waitDrain("vec_drain");
    end

    // Four channels offered together must issue back-to-back in channel order.
    doReset(1'b1);
    issueCycQ.delete();
    for (int k = 0; k < 4; k++) begin
      pushExpect(k, 32'h41000000 + 32'(k), 32'h40800000 + 32'(k << 4), 32'h3F800000,
                 fakeAdd(fakeMul(32'h40800000 + 32'(k << 4), 32'h41000000 + 32'(k)), 32'h3F800000));
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      ch_in_data[k*32 +: 32] = 32'h41000000 + 32'(k);
      ch_maxu_in[k*32 +: 32] = 32'h40800000 + 32'(k << 4);
    end
    mode = 2'd0;
    ch_in_valid = 4'hF;
    @(negedge clk);
    checkOutput("all_ready", 32'(ch_in_ready), 32'hF);
    @(posedge clk);
    #1;
    ch_in_valid = 4'h0;
    waitDrain("rr_drain");
    checkOutput("rr_issue_count", 32'(issueCycQ.size()), 32'd4);
    if (issueCycQ.size() == 4) begin
      for (int k = 1; k < 4; k++) begin
        checkOutput("rr_consecutive", 32'(issueCycQ[k] - issueCycQ[k-1]), 32'd1);
      end
    end

    // Adder stalled: only the tag depth may be in flight, then drain in order.
    addEn = 1'b0;
    base = issueCount;
    baseOut = outCount;
    offersDone = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          offerOp(0, 32'h3F000000 + 32'(i), 32'h40000000 + 32'(i * 3), 2'(i % 3));
        end
        offersDone = 1'b1;
      end
    join_none
    repeat (150) @(negedge clk);
    checkOutput("stall_issued", 32'(issueCount - base), 32'd16);
    checkOutput("stall_ready0", 32'(ch_in_ready[0]), 32'd0);
    checkOutput("stall_no_out", 32'(outCount - baseOut), 32'd0);
    addEn = 1'b1;
    n = 0;
    while (!offersDone && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("stall_offers_done", 32'(offersDone), 32'd1);
    waitDrain("stall_drain");
    checkOutput("stall_out_count", 32'(outCount - baseOut), 32'd20);
    checkOutput("seq_err_clean", 32'(seq_err), 32'd0);

    // Spurious add_rdy with nothing outstanding.
    baseOut = outCount;
    @(posedge clk);
    #1;
    forceAdd = 1'b1;
    @(posedge clk);
    #1;
    forceAdd = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("spur_add_err", 32'(seq_err), 32'd1);
    checkOutput("spur_add_no_out", 32'(outCount - baseOut), 32'd0);
    repeat (10) @(negedge clk);
    checkOutput("spur_add_sticky", 32'(seq_err), 32'd1);

    // Reset with three ops in flight; their late mult_rdy pulses are orphans.
    doReset(1'b1);
    checkOutput("seq_err_cleared", 32'(seq_err), 32'd0);
    multEn = 1'b0;
    offerOp(0, 32'h40000000, 32'h40400000, 2'd0);
    offerOp(1, 32'h40100000, 32'h40500000, 2'd1);
    offerOp(2, 32'h40200000, 32'h40600000, 2'd2);
    n = 0;
    while (mulQ.size() < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("inflight_count", 32'(mulQ.size()), 32'd3);
    doReset(1'b0);
    base = addValidCount;
    multEn = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("orphan_delivered", 32'(mulQ.size()), 32'd0);
    checkOutput("orphan_no_add", 32'(addValidCount - base), 32'd0);
    checkOutput("orphan_seq_err", 32'(seq_err), 32'd1);
    applyStimulus(3, 32'h40000000, 32'h40400000, 2'd1, 32'hBF800000, 32'h40A00000);
    waitDrain("post_reset_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/maxuhp_mc.md
MAXUHP_MC -- requirements
Module: maxuhp_mc

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 32, meaning IEEE-754 single-precision word width.
REQ-002 SHALL have parameter C_CH_NUM, default 4, meaning number of input channels (2..16).
REQ-003 SHALL have parameter C_TAG_DEPTH, default 16, meaning maximum outstanding operations; power of two.
REQ-004 SHALL have parameter C_ADD_CONST, default 32'h3F800000, meaning addend constant (+1.0).
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have ports ch_in_valid (input, C_CH_NUM) and ch_in_ready (output, C_CH_NUM), meaning the per-channel handshake.
REQ-008 SHALL have ports ch_in_data and ch_maxu_in, input, C_CH_NUM*C_DATA_WIDTH, meaning channel k operands x and maxu in slice k.
REQ-009 SHALL have port mode, input, 2, meaning 0: maxu*x+C; 1: maxu*x-C; 2: maxu*x+0.0; 3: same as 2.
REQ-010 SHALL have ports mult_a, mult_b (output, W), mult_valid (output, 1), mult_result (input, W) and mult_rdy (input, 1), meaning the external FP multiplier.
REQ-011 SHALL have ports add_a, add_b (output, W), add_valid (output, 1), add_result (input, W) and add_rdy (input, 1), meaning the external FP adder.
REQ-012 SHALL have ports dataf_out_valid (output, 1), dataf_out (output, W) and dataf_out_ch (output, clog2(C_CH_NUM)), meaning the result and its source channel.
REQ-013 SHALL have port seq_err, output, 1, meaning a sticky protocol-error flag.

Function
REQ-014 SHALL hold one entry per channel; ch_in_ready[k] = holding register k empty; data and mode SHALL be captured when valid&ready.
REQ-015 SHALL issue at most one op per cycle by round-robin over full holding registers, starting after the last channel granted, and only while outstanding < C_TAG_DEPTH.
REQ-016 On issue, SHALL register mult_a=maxu, mult_b=x and mult_valid=1 for exactly one cycle, free the holding register and push {ch, mode} into the tag FIFO.
REQ-017 On mult_rdy, SHALL drive add_a=mult_result, add_valid=1 and add_b per the mode at the mult read pointer on the next cycle: C_ADD_CONST, C_ADD_CONST with bit 31 inverted, or 32'h0. It SHALL then advance the mult read pointer.
REQ-018 On add_rdy, SHALL drive dataf_out=add_result, dataf_out_valid=1 and dataf_out_ch from the tag at the add read pointer on the next cycle. It SHALL then advance the add read pointer.
REQ-019 Outstanding counter SHALL increment on issue and decrement on accepted add_rdy; simultaneous events SHALL leave it unchanged.
REQ-020 Units SHALL be treated as in-order; results SHALL leave in issue order.
REQ-021 An mult_rdy with no un-multiplied tag, or an add_rdy with no tag pending addition, SHALL be ignored (no output, no pointer move) and SHALL set seq_err.
REQ-022 A full holding register SHALL be refillable in the same cycle it is issued only from the next cycle; ch_in_ready SHALL be registered.
REQ-023 Pointers SHALL wrap modulo C_TAG_DEPTH; counter SHALL never exceed C_TAG_DEPTH.

Reset
REQ-024 While reset=0, all outputs SHALL be 0, including ch_in_ready; ch_in_ready SHALL go to all-ones on the first edge after release.
REQ-025 Reset SHALL clear holding registers, pointers, counter, arbiter pointer (to ch0) and seq_err. In-flight ops SHALL be discarded, and their late rdy pulses SHALL be handled per REQ-021.

Structure
REQ-026 Package maxuhp_pkg SHALL hold the mode encodings, FP constants (+0.0, sign mask, +1.0) and a clog2 function.
REQ-027 Tag storage SHALL be sub-module maxuhp_tag_fifo: one write pointer, two read pointers, full/empty per pointer.

Verification
REQ-028 ch0 x=0x40000000, maxu=0x40400000, mode0, model mult->0x40C00000 -> add_b=0x3F800000, out 0x40E00000, ch=0.
REQ-029 Same operands, mode1 -> add_b=0xBF800000, out 0x40A00000; mode2 -> add_b=0x00000000, out 0x40C00000.
REQ-030 All 4 channels valid in one cycle -> mult_valid on 4 consecutive cycles, order ch0..3, outputs tagged 0,1,2,3.
REQ-031 add_rdy held low, 20 ops offered -> exactly 16 issued, then issue stalls and ready drops; releasing rdys drains all 20 in order.
REQ-032 add_rdy pulse with counter 0 -> seq_err=1 sticky, dataf_out_valid stays 0.
REQ-033 reset asserted with 3 ops in flight, then 3 mult_rdy pulses -> no add_valid, seq_err=1, new op afterwards completes normally.
